// File: rtl/mat_mult_seq_if.sv
// Operand-read and result-stream bundle for the sequential matrix multiplier.
// The sequencer drives the master side; operand memories and result sink sit on the slave side.
interface mat_mult_seq_if #(
  parameter int N  = 2,
  parameter int DW = 8
);
  localparam int AW   = $clog2(N*N);
  localparam int IW   = $clog2(N);
  localparam int ACCW = 2*DW + $clog2(N);

  logic            rd_en;
  logic [AW-1:0]   a_rd_addr;
  logic [AW-1:0]   b_rd_addr;
  logic [DW-1:0]   a_rd_data;
  logic [DW-1:0]   b_rd_data;
  logic            res_valid;
  logic            res_ready;
  logic [IW-1:0]   res_row;
  logic [IW-1:0]   res_col;
  logic [ACCW-1:0] res_data;

  modport master (
    output rd_en, a_rd_addr, b_rd_addr, res_valid, res_row, res_col, res_data,
    input  a_rd_data, b_rd_data, res_ready
  );

  modport slave (
    input  rd_en, a_rd_addr, b_rd_addr, res_valid, res_row, res_col, res_data,
    output a_rd_data, b_rd_data, res_ready
  );
endinterface

// File: rtl/mat_mult_seq.sv
// Time-shared signed MAC sequencer: C[i][j] = sum_k A[i][k]*B[j][k], streamed row-major.
// Operand memories have one cycle of read latency; results leave on a valid/ready port.
module mat_mult_seq #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  mat_mult_seq_if.master bus
);
  localparam int AW   = $clog2(N*N);
  localparam int IW   = $clog2(N);
  localparam int ACCW = 2*DW + $clog2(N);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_ACC  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [IW-1:0] LAST = IW'(N-1);
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [AW-1:0] N_A  = AW'(N);

  logic [2:0]             r_state;
  logic [IW-1:0]          r_i;
  logic [IW-1:0]          r_j;
  logic [IW-1:0]          r_k;
  logic signed [ACCW-1:0] r_acc;
  logic                   r_rd_d;
  logic                   r_first_d;

  logic signed [2*DW-1:0] w_a_ext;
  logic signed [2*DW-1:0] w_b_ext;
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] w_prod_ext;
  logic                   w_hs;

  assign w_a_ext    = {{DW{bus.a_rd_data[DW-1]}}, bus.a_rd_data};
  assign w_b_ext    = {{DW{bus.b_rd_data[DW-1]}}, bus.b_rd_data};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_hs       = bus.res_valid & bus.res_ready;

  // NOTE: every flop, including the accumulator, is cleared by the async reset so that
  // an aborted run can never leak a partial sum or stale indices onto the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_rd_d    <= 1'b0;
      r_first_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values; the
      // acc update below may be overridden by the IDLE clear later in this block.
      r_rd_d    <= (r_state == S_READ);
      r_first_d <= (r_state == S_READ) && (r_k == '0);
      // Read data trails rd_en by one cycle; the first return of an element overwrites.
      if (r_rd_d) r_acc <= r_first_d ? w_prod_ext : r_acc + w_prod_ext;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
          end
        end
        S_READ: begin
          if (r_k == LAST) begin
            r_k     <= '0;
            r_state <= S_ACC;
          end else begin
            r_k <= r_k + ONE;
          end
        end
        S_ACC: r_state <= S_OUT;
        S_OUT: begin
          if (w_hs) begin
            if (r_i == LAST && r_j == LAST) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_READ;
              r_k     <= '0;
              if (r_j == LAST) begin
                r_j <= '0;
                r_i <= r_i + ONE;
              end else begin
                r_j <= r_j + ONE;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_i     <= '0;
          r_j     <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (r_state == S_READ) || (r_state == S_ACC) || (r_state == S_OUT);
  assign done          = (r_state == S_DONE);
  assign bus.rd_en     = (r_state == S_READ);
  assign bus.a_rd_addr = AW'(r_i) * N_A + AW'(r_k);
  assign bus.b_rd_addr = AW'(r_j) * N_A + AW'(r_k);
  assign bus.res_valid = (r_state == S_OUT);
  assign bus.res_row   = r_i;
  assign bus.res_col   = r_j;
  assign bus.res_data  = r_acc;
endmodule
